// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
//   fetchState_t : sequencer state encoding (IDLE, FETCH, DRAIN, DONE)
//   WORD_BYTES   : byte stride between consecutive instruction words
//   INSTR_W      : instruction word width
//   CNT_W        : width of the statistics counters
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fetchState_t;

   localparam int WORD_BYTES = 4;
   localparam int INSTR_W    = 32;
   localparam int CNT_W      = 16;

endpackage

// File: rtl/fetch_stat_counter.sv
// Saturating event counter used for fetch statistics.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, clears count
//   clear  : synchronous clear, wins over inc
//   inc    : count one event this cycle
//   count  : current value, sticks at all-ones
module fetch_stat_counter
   import fetch_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer for the single-cycle datapath's combinational instruction
// memory. Owns the PC, presents it as the memory address and registers each
// returned word into a one-entry valid/ready slot toward decode. Handles
// redirects (flush + new PC), misaligned-redirect errors and a clean stop
// after the last loaded instruction.
//
// Optional build macro: FETCH_STATS_EN
//   defined   : fetch_cnt / stall_cnt are live 16-bit saturating counters
//   undefined : both ports read 0 and no counter flops exist
//
// Ports:
//   clk, rst_n        : clock (rising edge), async active-low reset
//   start             : begin at RESET_PC, honoured in IDLE or DONE only
//   imem_addr         : byte address to instruction memory (= PC)
//   imem_instr        : word returned combinationally for imem_addr
//   out_valid/ready   : handshake of the registered output slot
//   out_instr, out_pc : registered word and its byte address
//   redirect_valid/pc : taken branch/jump, flush and continue at redirect_pc
//   busy              : in FETCH or DRAIN
//   done              : normal completion, held until next start
//   err               : misaligned redirect, held until next start
//   fetch_cnt         : words delivered (out_valid && out_ready)
//   stall_cnt         : cycles with out_valid && !out_ready
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | after reset, waiting for start
// FETCH | presenting PC, capturing words into the slot
// DRAIN | last word just accepted, one settle cycle before DONE
// DONE  | program ended (done) or aborted (err), PC frozen
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                NUM_INSTR = 3,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [CNT_W-1:0]   fetch_cnt,
   output logic [CNT_W-1:0]   stall_cnt
);

   localparam logic [ADDR_W-3:0] IDX_LIMIT = (ADDR_W-2)'(NUM_INSTR);
   localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(WORD_BYTES);

   fetchState_t        state, stateNext;
   logic [ADDR_W-1:0]  pc, pcNext;
   logic               validReg, validNext;
   logic [INSTR_W-1:0] instrReg, instrNext;
   logic [ADDR_W-1:0]  outPcReg, outPcNext;
   logic               errReg, errNext;

   logic               slotFree;
   logic               accept;
   logic               inRange;
   logic               redirMisaligned;
   logic               startOk;

   assign accept          = validReg && out_ready;
   assign slotFree        = !validReg || out_ready;
   assign inRange         = pc[ADDR_W-1:2] < IDX_LIMIT;
   assign redirMisaligned = redirect_pc[1:0] != 2'b00;
   assign startOk         = start && ((state == IDLE) || (state == DONE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         validReg <= 1'b0;
         instrReg <= '0;
         outPcReg <= '0;
         errReg   <= 1'b0;
      end else begin
         state    <= stateNext;
         pc       <= pcNext;
         validReg <= validNext;
         instrReg <= instrNext;
         outPcReg <= outPcNext;
         errReg   <= errNext;
      end
   end

   always_comb begin
      stateNext = state;
      pcNext    = pc;
      validNext = validReg;
      instrNext = instrReg;
      outPcNext = outPcReg;
      errNext   = errReg;

      unique case (state)
         IDLE, DONE: begin
            validNext = 1'b0;
            if (start) begin
               pcNext    = RESET_PC;
               errNext   = 1'b0;
               stateNext = FETCH;
            end
         end

         FETCH: begin
            if (redirect_valid) begin
               // Flush wins over capture; an accept in the same cycle still
               // completes on the handshake side.
               validNext = 1'b0;
               if (redirMisaligned) begin
                  errNext   = 1'b1;
                  stateNext = DONE;
               end else begin
                  pcNext = redirect_pc;
               end
            end else if (slotFree && inRange) begin
               instrNext = imem_instr;
               outPcNext = pc;
               validNext = 1'b1;
               pcNext    = pc + PC_STEP;
            end else if (slotFree) begin
               // Past the end: settle one cycle if the last word just left,
               // so done never overlaps out_valid.
               validNext = 1'b0;
               stateNext = accept ? DRAIN : DONE;
            end
         end

         DRAIN: begin
            validNext = 1'b0;
            if (redirect_valid) begin
               if (redirMisaligned) begin
                  errNext   = 1'b1;
                  stateNext = DONE;
               end else begin
                  pcNext    = redirect_pc;
                  stateNext = FETCH;
               end
            end else begin
               stateNext = DONE;
            end
         end

         default: begin
            stateNext = IDLE;
            validNext = 1'b0;
         end
      endcase
   end

   assign imem_addr = pc;
   assign out_valid = validReg;
   assign out_instr = instrReg;
   assign out_pc    = outPcReg;
   assign busy      = (state == FETCH) || (state == DRAIN);
   assign done      = (state == DONE) && !errReg;
   assign err       = errReg;

`ifdef FETCH_STATS_EN
   logic stallEvt;

   assign stallEvt = validReg && !out_ready;

   fetch_stat_counter uFetchCnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (startOk),
      .inc   (accept),
      .count (fetch_cnt)
   );

   fetch_stat_counter uStallCnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (startOk),
      .inc   (stallEvt),
      .count (stall_cnt)
   );
`else
   logic unusedStats;

   assign unusedStats = startOk;
   assign fetch_cnt   = '0;
   assign stall_cnt   = '0;
`endif

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controller that sequences the combinational instruction memory of the single-cycle datapath.
- Owns the program counter and drives the memory word address, one address per fetch.
- Registers each fetched word into a one-entry output slot with a valid/ready handshake toward decode.
- Accepts branch/jump redirects with flush, and stops cleanly past the last loaded instruction.

Parameters:
- NUM_INSTR, 3, number of instruction words loaded in instruction memory; fetch beyond this index ends the program.
- RESET_PC, 32'h0000_0000, byte address of the first fetch after start.
- ADDR_W, 32, width of PC / memory address.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: begin fetching at RESET_PC; honoured only in IDLE or DONE.
- imem_addr  out  ADDR_W  byte address to instruction memory (equals current PC).
- imem_instr  in  32  instruction word returned combinationally for imem_addr.
- out_valid  out  1  output slot holds an instruction.
- out_ready  in  1  decode accepts the slot this cycle.
- out_instr  out  32  registered instruction word.
- out_pc  out  ADDR_W  byte address of out_instr.
- redirect_valid  in  1  branch/jump taken: flush and continue at redirect_pc.
- redirect_pc  in  ADDR_W  target byte address.
- busy  out  1  state is FETCH or DRAIN.
- done  out  1  program finished normally; held until the next start.
- err  out  1  misaligned redirect; held until the next start.
- fetch_cnt  out  16  instructions delivered (see Optional Feature).
- stall_cnt  out  16  cycles with out_valid=1 and out_ready=0 (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC.
  - out_valid=0, out_instr=0, out_pc=0.
  - done=0, err=0, counters=0.
  - Reset asserted mid-fetch discards the slot immediately.
- imem_addr = pc at all times (combinational from the register). Memory word index = pc[ADDR_W-1:2].
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE/DONE + start:
  - pc<=RESET_PC, done<=0, err<=0, out_valid<=0, counters cleared; go to FETCH.
  - start in FETCH/DRAIN is ignored.
- FETCH, "slot free" = (out_valid==0 || out_ready==1):
  - Priority 1, redirect_valid=1:
    - out_valid<=0 (flush, including a word being accepted this cycle: the accept still counts as delivered).
    - If redirect_pc[1:0]!=0: err<=1, go to DONE, done stays 0.
    - Otherwise pc<=redirect_pc.
  - Priority 2, slot free and word index < NUM_INSTR:
    - out_instr<=imem_instr, out_pc<=pc, out_valid<=1, pc<=pc+4.
    - Latency: word visible at out_* one cycle after pc presents it.
  - Priority 3, slot free and word index >= NUM_INSTR:
    - out_valid<=0; go to DRAIN if a word was just accepted, else DONE.
  - Slot not free: hold pc and the slot unchanged.
- DRAIN: out_valid is 0; go to DONE next cycle (one-cycle settle so done never overlaps out_valid). A redirect in DRAIN is applied as in FETCH and returns to FETCH.
- DONE: done=1 (unless err), out_valid=0, pc frozen.
- Throughput: one instruction per cycle when out_ready stays high.
- Width/arithmetic rules:
  - pc+4 wraps modulo 2^ADDR_W.
  - Index compare is unsigned; a wrapped PC is simply index >= NUM_INSTR unless it lands below it.
  - A redirect to an index >= NUM_INSTR ends the program on the next free slot.
- Simultaneous out_ready and redirect_valid: the accept completes and the slot is flushed; no new capture that cycle.

Optional Feature:
- Macro FETCH_STATS_EN.
- Defined:
  - fetch_cnt increments on each out_valid&&out_ready.
  - stall_cnt increments on each out_valid&&!out_ready.
  - Both 16-bit saturating at 16'hFFFF, cleared on reset and start.
- Undefined: both ports are tied to 0 and no counter flops are built; ports remain present.

Decomposition:
- Shared package fetch_pkg:
  - state enum (IDLE, FETCH, DRAIN, DONE).
  - WORD_BYTES=4, INSTR_W=32.
  - localparam for counter width (16).
- One natural sub-module: fetch_stat_counter, a saturating 16-bit counter with clear and increment. Instantiated twice under FETCH_STATS_EN.

Test Plan:
- Memory words A,B,C with NUM_INSTR=3; start with out_ready=1 -> out_pc 0,4,8 on consecutive cycles with words A,B,C; done=1 two cycles after C accepted; fetch_cnt=3.
- out_ready=0 for 4 cycles after first capture -> out_instr=A held, pc stays 4, stall_cnt=4, then B follows the cycle after out_ready=1.
- Redirect to 0 while out_pc=4 is valid -> next cycle out_valid=0, following cycle out_pc=0 word A; fetch_cnt unaffected by the flushed word.
- Redirect to 32'h6 -> err=1, done=0, state DONE, out_valid=0; a later start clears err and fetches from 0.
- rst_n low while out_valid=1 mid-program -> out_valid=0, busy=0, done=0 immediately (asynchronously); start afterward restarts at RESET_PC.
- start pulsed during FETCH -> ignored, with the sequence identical to the run with no pulse; start in DONE -> restarts, done cleared.
